// File: rtl/wb_master_engine.sv
// Wishbone classic master engine: queues commands in a small circular FIFO and
// runs them one at a time on the bus, returning one response per command with
// error and timeout status.
module wb_master_engine #(
  parameter int WB_ADDR_WIDTH = 32,
  parameter int WB_DATA_WIDTH = 32,
  parameter int CMD_DEPTH     = 4,
  parameter int TIMEOUT       = 255
) (
  input  logic                       clk,
  input  logic                       rstn,
  // command side
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [WB_ADDR_WIDTH-1:0]   cmd_adr,
  input  logic                       cmd_we,
  input  logic [WB_DATA_WIDTH/8-1:0] cmd_sel,
  input  logic [WB_DATA_WIDTH-1:0]   cmd_dat,
  // response side
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WB_DATA_WIDTH-1:0]   rsp_dat,
  output logic                       rsp_err,
  output logic                       rsp_timeout,
  // Wishbone master
  output logic                       CYC,
  output logic                       STB,
  output logic                       WE,
  output logic [WB_ADDR_WIDTH-1:0]   ADR,
  output logic [WB_DATA_WIDTH/8-1:0] SEL,
  output logic [WB_DATA_WIDTH-1:0]   DAT_W,
  input  logic [WB_DATA_WIDTH-1:0]   DAT_R,
  input  logic                       ACK,
  input  logic                       ERR,
  output logic                       busy
);

  localparam int SEL_W = WB_DATA_WIDTH / 8;
  localparam int PTR_W = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
  localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUS, RSP} state_t;

  // command storage, no reset needed: validity is tracked by the counter
  logic [WB_ADDR_WIDTH-1:0] fifo_adr [CMD_DEPTH];
  logic                     fifo_we  [CMD_DEPTH];
  logic [SEL_W-1:0]         fifo_sel [CMD_DEPTH];
  logic [WB_DATA_WIDTH-1:0] fifo_dat [CMD_DEPTH];

  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push, pop, fifo_empty;

  state_t                   state_reg, state_next;
  logic                     cyc_reg, cyc_next;
  logic                     we_reg, we_next;
  logic [WB_ADDR_WIDTH-1:0] adr_reg, adr_next;
  logic [SEL_W-1:0]         sel_reg, sel_next;
  logic [WB_DATA_WIDTH-1:0] datw_reg, datw_next;
  logic [15:0]              tmo_reg, tmo_next;
  logic                     rsp_valid_reg, rsp_valid_next;
  logic [WB_DATA_WIDTH-1:0] rsp_dat_reg, rsp_dat_next;
  logic                     rsp_err_reg, rsp_err_next;
  logic                     rsp_tmo_reg, rsp_tmo_next;

  assign fifo_empty = (count_reg == '0);
  assign cmd_ready  = (count_reg != FULL_CNT);
  assign push       = cmd_valid && cmd_ready;
  // the head is consumed only when the engine is idle; one command in flight
  assign pop        = (state_reg == IDLE) && !fifo_empty;

  // write accepted commands into the circular store
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_adr[wr_ptr_reg] <= cmd_adr;
      fifo_we[wr_ptr_reg]  <= cmd_we;
      fifo_sel[wr_ptr_reg] <= cmd_sel;
      fifo_dat[wr_ptr_reg] <= cmd_dat;
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop cancel out
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // next-state and registered-output logic for IDLE -> BUS -> RSP
  always_comb begin
    state_next     = state_reg;
    cyc_next       = cyc_reg;
    we_next        = we_reg;
    adr_next       = adr_reg;
    sel_next       = sel_reg;
    datw_next      = datw_reg;
    tmo_next       = tmo_reg;
    rsp_valid_next = rsp_valid_reg;
    rsp_dat_next   = rsp_dat_reg;
    rsp_err_next   = rsp_err_reg;
    rsp_tmo_next   = rsp_tmo_reg;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          adr_next   = fifo_adr[rd_ptr_reg];
          we_next    = fifo_we[rd_ptr_reg];
          sel_next   = fifo_sel[rd_ptr_reg];
          datw_next  = fifo_dat[rd_ptr_reg];
          cyc_next   = 1'b1;
          tmo_next   = '0;
          state_next = BUS;
        end
      end
      BUS: begin
        if (ERR == 1'b1) begin
          // error wins over a simultaneous acknowledge
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = '0;
          rsp_err_next   = 1'b1;
          rsp_tmo_next   = 1'b0;
          state_next     = RSP;
        end else if (ACK == 1'b1) begin
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = we_reg ? '0 : DAT_R;
          rsp_err_next   = 1'b0;
          rsp_tmo_next   = 1'b0;
          state_next     = RSP;
        end else if (tmo_reg == TMO_LAST) begin
          // this is the TIMEOUT-th silent cycle: abandon the transfer
          cyc_next       = 1'b0;
          rsp_valid_next = 1'b1;
          rsp_dat_next   = '0;
          rsp_err_next   = 1'b0;
          rsp_tmo_next   = 1'b1;
          state_next     = RSP;
        end else begin
          tmo_next = tmo_reg + 16'd1;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_next = 1'b0;
          state_next     = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // state and output registers; reset clears the bus immediately
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= IDLE;
      cyc_reg       <= 1'b0;
      we_reg        <= 1'b0;
      adr_reg       <= '0;
      sel_reg       <= '0;
      datw_reg      <= '0;
      tmo_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_dat_reg   <= '0;
      rsp_err_reg   <= 1'b0;
      rsp_tmo_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cyc_reg       <= cyc_next;
      we_reg        <= we_next;
      adr_reg       <= adr_next;
      sel_reg       <= sel_next;
      datw_reg      <= datw_next;
      tmo_reg       <= tmo_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_dat_reg   <= rsp_dat_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_tmo_reg   <= rsp_tmo_next;
    end
  end

  assign CYC         = cyc_reg;
  assign STB         = cyc_reg;
  assign WE          = we_reg;
  assign ADR         = adr_reg;
  assign SEL         = sel_reg;
  assign DAT_W       = datw_reg;
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_dat     = rsp_dat_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_tmo_reg;
  assign busy        = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_wb_master_engine.sv
// Scoreboard bench for wb_master_engine: stimulus pushes expected responses,
// a monitor pops and compares on every response handshake.
module tb_wb_master_engine;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_adr = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] cmd_dat = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_dat;
  logic        rsp_err, rsp_timeout;
  logic        CYC, STB, WE;
  logic [31:0] ADR, DAT_W, DAT_R;
  logic [3:0]  SEL;
  logic        ACK, ERR, busy;

  // slave model: mode 0=ACK, 1=ERR, 2=ACK+ERR, 3=silent; replies after wait_cfg cycles
  int          mode = 0;
  int          wait_cfg = 0;
  int          wcnt = 0;
  logic        hit;

  int checks = 0;
  int passes = 0;
  int rsp_cnt = 0;
  int cyc_cur = 0;
  int cyc_last = 0;
  int cyc_seen = 0;
  logic [33:0] sb[$];   // {dat, err, timeout}

  always #5 clk = ~clk;

  wb_master_engine #(
    .WB_ADDR_WIDTH(32), .WB_DATA_WIDTH(32), .CMD_DEPTH(4), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_adr(cmd_adr),
    .cmd_we(cmd_we), .cmd_sel(cmd_sel), .cmd_dat(cmd_dat),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR), .SEL(SEL), .DAT_W(DAT_W),
    .DAT_R(DAT_R), .ACK(ACK), .ERR(ERR), .busy(busy)
  );

  assign hit   = CYC && STB && (wcnt == wait_cfg);
  assign ACK   = hit && (mode == 0 || mode == 2);
  assign ERR   = hit && (mode == 1 || mode == 2);
  assign DAT_R = (ADR == 32'h20) ? 32'h1234_5678 : {16'hA5A5, ADR[15:0]};

  // slave wait-state counter
  always @(posedge clk) begin
    if (CYC && STB && !(ACK || ERR)) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end

  // measure how many cycles CYC stays high per transaction
  always @(negedge clk) begin
    if (CYC) begin
      cyc_cur  <= cyc_cur + 1;
      cyc_seen <= cyc_seen + 1;
    end else if (cyc_cur != 0) begin
      cyc_last <= cyc_cur;
      cyc_cur  <= 0;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // monitor: compare every consumed response against the scoreboard head
  always @(negedge clk) begin
    if (rstn && rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {30'd0, rsp_dat, rsp_err, rsp_timeout}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        $display("rsp #%0d dat=%08h err=%0b tmo=%0b", rsp_cnt, rsp_dat, rsp_err, rsp_timeout);
        chk("rsp", {30'd0, rsp_dat, rsp_err, rsp_timeout}, {30'd0, e});
      end
    end
  end

  task automatic send_cmd(input logic [31:0] adr, input logic we, input logic [3:0] sel,
                          input logic [31:0] dat, input logic [33:0] exp, input bit push_exp);
    bit got = 0;
    if (push_exp) sb.push_back(exp);
    cmd_adr = adr; cmd_we = we; cmd_sel = sel; cmd_dat = dat; cmd_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cmd_ready) begin got = 1; break; end
    end
    if (!got) chk("cmd_accept_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    $display("cmd adr=%08h we=%0b sel=%h dat=%08h accepted=%0b", adr, we, sel, dat, got);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) begin done = 1; break; end
    end
    if (!done) chk("idle_timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
  endtask

  logic [31:0] bp_dat [6] = '{32'hA5A5_0100, 32'hA5A5_0101, 32'hA5A5_0102,
                              32'hA5A5_0103, 32'hA5A5_0104, 32'hA5A5_0105};
  int rsp_before;
  int seen_before;

  initial begin
    // reset values while rstn is low
    #3;
    chk("rst_cyc", {63'd0, CYC}, 64'd0);
    chk("rst_stb_we", {62'd0, STB, WE}, 64'd0);
    chk("rst_adr_sel_datw", {ADR, SEL, 28'd0} | {32'd0, DAT_W}, 64'd0);
    chk("rst_rsp", {29'd0, rsp_valid, rsp_err, rsp_timeout, rsp_dat}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    #14 rstn = 1'b1;
    @(posedge clk); #1;
    chk("cmd_ready_after_rst", {63'd0, cmd_ready}, 64'd1);

    // write, ACK two cycles after CYC rises
    mode = 0; wait_cfg = 2;
    send_cmd(32'h10, 1'b1, 4'hF, 32'hDEAD_BEEF, {32'h0, 1'b0, 1'b0}, 1);
    @(negedge clk);
    chk("lat_cyc_low", {62'd0, CYC, busy}, 64'd1);
    @(negedge clk);
    chk("wr_bus_ctrl", {58'd0, CYC, STB, WE, SEL}, {58'd0, 3'b111, 4'hF});
    chk("wr_bus_adr_dat", {ADR, DAT_W}, {32'h10, 32'hDEAD_BEEF});
    wait_idle();
    chk("wr_cyc_len", 64'(cyc_last), 64'd3);

    // read returning 0x12345678
    mode = 0; wait_cfg = 1;
    send_cmd(32'h20, 1'b0, 4'hF, 32'h0, {32'h1234_5678, 1'b0, 1'b0}, 1);
    wait_idle();
    chk("rd_cyc_len", 64'(cyc_last), 64'd2);

    // timeout: silent slave
    mode = 3; wait_cfg = 0;
    send_cmd(32'h40, 1'b0, 4'hF, 32'h0, {32'h0, 1'b0, 1'b1}, 1);
    wait_idle();
    chk("tmo_cyc_len", 64'(cyc_last), 64'd8);

    // ACK and ERR together on a read: error wins, data zero
    mode = 2; wait_cfg = 1;
    send_cmd(32'h30, 1'b0, 4'hF, 32'h0, {32'h0, 1'b1, 1'b0}, 1);
    wait_idle();

    // ERR only on a write
    mode = 1; wait_cfg = 0;
    send_cmd(32'h50, 1'b1, 4'h3, 32'h0000_BEEF, {32'h0, 1'b1, 1'b0}, 1);
    wait_idle();

    // backpressure: response stalled, FIFO fills, order preserved
    mode = 0; wait_cfg = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_cmd(32'h100 + 32'(i), 1'b0, 4'hF, 32'h0, {bp_dat[i], 1'b0, 1'b0}, 1);
    @(negedge clk);
    chk("bp_full", {62'd0, cmd_ready, rsp_valid}, 64'd1);
    fork
      send_cmd(32'h105, 1'b0, 4'hF, 32'h0, {bp_dat[5], 1'b0, 1'b0}, 1);
      begin
        repeat (3) @(negedge clk);
        chk("bp_still_full", {63'd0, cmd_ready}, 64'd0);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    chk("bp_rsp_count", 64'(rsp_cnt), 64'd11);

    // asynchronous reset while a transfer is on the bus with commands queued
    mode = 3;
    send_cmd(32'h200, 1'b1, 4'hF, 32'h1111_1111, 34'd0, 0);
    send_cmd(32'h204, 1'b1, 4'hF, 32'h2222_2222, 34'd0, 0);
    send_cmd(32'h208, 1'b1, 4'hF, 32'h3333_3333, 34'd0, 0);
    chk("mid_bus_cyc", {62'd0, CYC, busy}, 64'd3);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_drop", {60'd0, CYC, STB, busy, rsp_valid}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    rsp_before  = rsp_cnt;
    seen_before = cyc_seen;
    repeat (30) @(negedge clk);
    chk("post_rst_quiet", {32'(cyc_seen - seen_before), 32'(rsp_cnt - rsp_before)}, 64'd0);
    chk("post_rst_idle", {62'd0, busy, cmd_ready}, 64'd1);
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
